io_store_unit: RTL and testbench
================================

# io_store_unit

Memory-mapped I/O write side of the core. It sits beside the stage-3 load/IO-read path and takes stage-3 stores whose address falls in the I/O region (`addr[31:30] == 2'b10`). Writes to the UART transmit-data register go into a small TX FIFO that drives the UART transmitter over a valid/ready handshake. Writes to the counter-reset register clear the cycle and instruction counters, which this block owns and exports to the I/O read mux.

## Interface

- `TX_DEPTH`, default 4: TX FIFO entries; a power of two, at least 2.

- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `store_valid` in 1: stage-3 store present this cycle.
- `store_addr` in 32: store byte address.
- `store_data` in 32: store data, already lane-aligned.
- `store_be` in 4: byte enables; a write is performed only when `|store_be`.
- `instr_retire` in 1: one instruction retired this cycle.
- `uart_tx_data_in_valid` out 1: a TX byte is offered to the UART.
- `uart_tx_data_in` out 8: the TX byte.
- `uart_tx_data_in_ready` in 1: the UART accepts the byte.
- `tx_ready_status` out 1: the FIFO can accept a byte; this is bit 0 of the UART control register at 0x80000000.
- `cyc_counter` out 32: cycle counter (register 0x80000010).
- `instr_counter` out 32: retired-instruction counter (register 0x80000014).
- `tx_overflow` out 1: sticky flag; a TX write was dropped.

## Operation

- Decode: `io_wr = store_valid & (store_addr[31:30]==2'b10) & |store_be`.
  - TX write: `io_wr & store_addr[7:0]==8'h08`. Pushes `store_data[7:0]`; the byte enables are not examined further.
  - Counter reset: `io_wr & store_addr[7:0]==8'h18`. The data value is ignored.
  - Any other I/O address, and any non-I/O store, has no effect.
- TX FIFO: circular buffer with read/write pointers and an occupancy count running 0..`TX_DEPTH`.
  - Pop: `uart_tx_data_in_valid & uart_tx_data_in_ready`.
  - Push is accepted when count < `TX_DEPTH`, or when a pop happens in the same cycle.
  - A push while full with no pop is dropped and sets `tx_overflow`. FIFO contents do not change.
  - Simultaneous push and pop leaves the count unchanged; both pointers advance.
  - Pointers wrap modulo `TX_DEPTH`.
- Handshake toward the UART:
  - `uart_tx_data_in_valid = (count != 0)`.
  - `uart_tx_data_in` is the head entry. It is held stable while valid is high and ready is low.
  - Valid never drops without a pop.
- `tx_ready_status = (count < TX_DEPTH)`, derived from registered state only.
- `cyc_counter`: increments by 1 every cycle, wrapping 0xFFFFFFFF to 0.
- `instr_counter`: increments by 1 in each cycle with `instr_retire`, with the same wrap.
- Counter-reset write: both counters read 0 in the next cycle. The reset has priority over the increment in that cycle, including a coincident `instr_retire`.
- `tx_overflow` is cleared only by `rst`.

## Timing

- Reset values (asynchronous, on `rst`=0):
  - count = 0, both pointers = 0;
  - `uart_tx_data_in_valid` = 0, `uart_tx_data_in` = 0;
  - `tx_ready_status` = 1;
  - `cyc_counter` = 0, `instr_counter` = 0;
  - `tx_overflow` = 0.
- Reset mid-operation discards all FIFO contents. Valid drops immediately, asynchronously.
- First rising edge after `rst` deasserts: `cyc_counter` becomes 1.
- Store to valid latency:
  - A TX write at edge N into an empty FIFO gives `uart_tx_data_in_valid`=1 after edge N. There is no combinational bypass.
  - A byte accepted at edge N leaves the FIFO at edge N; the next entry is presented after edge N.
- Back-to-back:
  - One push per cycle is sustained.
  - One pop per cycle is sustained when the UART holds ready high.
- `tx_ready_status` falls in the cycle after the push that fills the FIFO. Software must poll it before each TX write; a write that ignores it is dropped and flagged.
- Counter-reset store at edge N: both counters read 0 after edge N and 1 (`cyc_counter`) after edge N+1.
- There are no combinational paths from `store_*` or `uart_tx_data_in_ready` to any output.

## Test plan

- Reset then idle for 10 cycles, no stores: valid stays 0, `tx_ready_status`=1, `cyc_counter`=10, `instr_counter`=0, `tx_overflow`=0.
- Stores of 0x41, 0x42, 0x43 to 0x80000008 on consecutive cycles with ready tied high: the UART receives 0x41, 0x42, 0x43 in order, on consecutive cycles, starting one cycle after the first store.
- Ready held low, 5 TX writes (0x10..0x14) with `TX_DEPTH`=4:
  - `tx_ready_status`=0 after the 4th write;
  - the 5th write is dropped and `tx_overflow`=1;
  - on releasing ready, exactly 0x10..0x13 drain.
- FIFO full, push of 0x55 in the same cycle as a pop: count stays 4, no overflow, and 0x55 emerges last.
- Counter reset:
  - preload via 300 cycles and 120 retires, then store to 0x80000018 with `instr_retire`=1 in that cycle;
  - next cycle both counters read 0, then `cyc_counter`=1.
- Negative decode:
  - stores to 0x80000004, to 0x00000008, and to 0x80000008 with `store_be`=4'b0000 cause no push and no counter change;
  - assert `rst`=0 with 2 bytes queued: valid drops immediately and count is 0.

Source files
------------

// File: rtl/io_store_unit.sv
// Memory-mapped I/O write side: decodes stage-3 stores into the UART TX FIFO
// and the counter-reset register, and owns the cycle/instruction counters.
module io_store_unit #(
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_valid,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  input  logic [3:0]  store_be,
  input  logic        instr_retire,
  output logic        uart_tx_data_in_valid,
  output logic [7:0]  uart_tx_data_in,
  input  logic        uart_tx_data_in_ready,
  output logic        tx_ready_status,
  output logic [31:0] cyc_counter,
  output logic [31:0] instr_counter,
  output logic        tx_overflow
);

  localparam int unsigned PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
  localparam int unsigned CW = $clog2(TX_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(TX_DEPTH);

  logic [7:0]    mem [TX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic io_wr;
  logic tx_wr;
  logic ctr_clr;
  logic pop;
  logic push_ok;

  // Only the low byte of data and the decoded address bits matter here.
  logic unused_bits;
  assign unused_bits = ^{store_data[31:8], store_addr[29:8]};

  always_comb begin
    io_wr   = store_valid && (store_addr[31:30] == 2'b10) && (|store_be);
    tx_wr   = io_wr && (store_addr[7:0] == 8'h08);
    ctr_clr = io_wr && (store_addr[7:0] == 8'h18);
    pop     = uart_tx_data_in_valid && uart_tx_data_in_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok = tx_wr && ((count < FULL) || pop);
  end

  assign uart_tx_data_in_valid = (count != '0);
  assign uart_tx_data_in       = mem[rd_ptr];
  assign tx_ready_status       = (count < FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < TX_DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= store_data[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (tx_wr && !push_ok) tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_counter   <= '0;
      instr_counter <= '0;
    end else if (ctr_clr) begin
      cyc_counter   <= '0;
      instr_counter <= '0;
    end else begin
      cyc_counter <= cyc_counter + 32'd1;
      if (instr_retire) instr_counter <= instr_counter + 32'd1;
    end
  end

endmodule

// File: tb/tb_io_store_unit.sv
// Scoreboard bench for io_store_unit: expected TX bytes are queued on each
// accepted store and compared as the UART handshake consumes them.
module tb_io_store_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        store_valid = 1'b0;
  logic [31:0] store_addr = '0;
  logic [31:0] store_data = '0;
  logic [3:0]  store_be = '0;
  logic        instr_retire = 1'b0;
  logic        valid;
  logic [7:0]  data;
  logic        ready = 1'b0;
  logic        tx_ready_status;
  logic [31:0] cyc_counter;
  logic [31:0] instr_counter;
  logic        tx_overflow;

  int checks = 0;
  int failures = 0;
  int tb_cyc = 0;
  int rx_n = 0;
  logic [7:0] exp_q[$];
  int rx_t[$];

  io_store_unit #(.TX_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .store_valid(store_valid),
    .store_addr(store_addr),
    .store_data(store_data),
    .store_be(store_be),
    .instr_retire(instr_retire),
    .uart_tx_data_in_valid(valid),
    .uart_tx_data_in(data),
    .uart_tx_data_in_ready(ready),
    .tx_ready_status(tx_ready_status),
    .cyc_counter(cyc_counter),
    .instr_counter(instr_counter),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // A handshake seen at the negedge completes at the following posedge.
  always @(negedge clk) begin
    if (rst && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected got=%02h expected=none", data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          failures++;
          $display("FAIL tx_byte got=%02h expected=%02h", data, e);
        end
      end
      rx_t.push_back(tb_cyc);
      rx_n++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    store_valid = 1'b1;
    store_addr  = a;
    store_data  = d;
    store_be    = be;
    step();
    store_valid = 1'b0;
    store_be    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rx_t.delete();
    rx_n = 0;
    ready = 1'b0;
    instr_retire = 1'b0;
    store_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b expected=0", valid); end
    if (data !== 8'h00) begin failures++; $display("FAIL rst_data got=%02h expected=00", data); end
    if (tx_ready_status !== 1'b1) begin failures++; $display("FAIL rst_txrdy got=%b expected=1", tx_ready_status); end
    if (cyc_counter !== 32'd0) begin failures++; $display("FAIL rst_cyc got=%0d expected=0", cyc_counter); end
    if (instr_counter !== 32'd0) begin failures++; $display("FAIL rst_instr got=%0d expected=0", instr_counter); end
    if (tx_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b expected=0", tx_overflow); end
    rst = 1'b1;
    repeat (10) step();
    checks += 5;
    if (valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b expected=0", valid); end
    if (tx_ready_status !== 1'b1) begin failures++; $display("FAIL idle_txrdy got=%b expected=1", tx_ready_status); end
    if (cyc_counter !== 32'd10) begin failures++; $display("FAIL idle_cyc got=%0d expected=10", cyc_counter); end
    if (instr_counter !== 32'd0) begin failures++; $display("FAIL idle_instr got=%0d expected=0", instr_counter); end
    if (tx_overflow !== 1'b0) begin failures++; $display("FAIL idle_ovf got=%b expected=0", tx_overflow); end
  endtask

  task automatic test_stream();
    int n0;
    do_reset();
    ready = 1'b1;
    rx_t.delete();
    step();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h41 + 8'(i));
      store(32'h8000_0008, 32'hFFFF_FF41 + i, 4'b0001);
      if (i == 0) n0 = tb_cyc;
    end
    repeat (4) step();
    checks++;
    if (rx_t.size() != 3) begin
      failures++;
      $display("FAIL stream_count got=%0d expected=3", rx_t.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_t[i] != n0 + i) begin
          failures++;
          $display("FAIL stream_timing idx=%0d got=%0d expected=%0d", i, rx_t[i], n0 + i);
        end
      end
    end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL stream_idle got=%b expected=0", valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back(8'h10 + 8'(i));
      store(32'h8000_0008, 32'h10 + i, 4'b1111);
      checks++;
      if (tx_ready_status !== (i < 3)) begin
        failures++;
        $display("FAIL ovf_txrdy write=%0d got=%b expected=%b", i + 1, tx_ready_status, (i < 3));
      end
      if (i == 3) begin
        checks++;
        if (tx_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b expected=0", tx_overflow); end
      end
    end
    checks += 3;
    if (tx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b expected=1", tx_overflow); end
    if (valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b expected=1", valid); end
    if (data !== 8'h10) begin failures++; $display("FAIL ovf_head got=%02h expected=10", data); end
    rx_n = 0;
    ready = 1'b1;
    repeat (8) step();
    checks += 3;
    if (rx_n != 4) begin failures++; $display("FAIL ovf_drain got=%0d expected=4", rx_n); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL ovf_left got=%0d expected=0", exp_q.size()); end
    if (tx_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b expected=1", tx_overflow); end
    ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'hA0 + 8'(i));
      store(32'h8000_0008, 32'hA0 + i, 4'b0001);
    end
    ready = 1'b1;
    exp_q.push_back(8'h55);
    store(32'h8000_0008, 32'h55, 4'b0001);
    ready = 1'b0;
    checks += 3;
    if (tx_ready_status !== 1'b0) begin failures++; $display("FAIL fullpop_count got=%b expected=0", tx_ready_status); end
    if (tx_overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%b expected=0", tx_overflow); end
    if (data !== 8'hA1) begin failures++; $display("FAIL fullpop_head got=%02h expected=a1", data); end
    rx_n = 0;
    ready = 1'b1;
    repeat (7) step();
    checks += 2;
    if (rx_n != 4) begin failures++; $display("FAIL fullpop_drain got=%0d expected=4", rx_n); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL fullpop_left got=%0d expected=0", exp_q.size()); end
    ready = 1'b0;
  endtask

  task automatic test_counters();
    do_reset();
    instr_retire = 1'b1;
    repeat (120) step();
    instr_retire = 1'b0;
    repeat (180) step();
    checks += 2;
    if (cyc_counter !== 32'd300) begin failures++; $display("FAIL ctr_cyc_pre got=%0d expected=300", cyc_counter); end
    if (instr_counter !== 32'd120) begin failures++; $display("FAIL ctr_instr_pre got=%0d expected=120", instr_counter); end
    instr_retire = 1'b1;
    store(32'h8000_0018, 32'hDEAD_BEEF, 4'b1111);
    instr_retire = 1'b0;
    checks += 2;
    if (cyc_counter !== 32'd0) begin failures++; $display("FAIL ctr_cyc_clr got=%0d expected=0", cyc_counter); end
    if (instr_counter !== 32'd0) begin failures++; $display("FAIL ctr_instr_clr got=%0d expected=0", instr_counter); end
    step();
    checks += 2;
    if (cyc_counter !== 32'd1) begin failures++; $display("FAIL ctr_cyc_next got=%0d expected=1", cyc_counter); end
    if (instr_counter !== 32'd0) begin failures++; $display("FAIL ctr_instr_next got=%0d expected=0", instr_counter); end
  endtask

  task automatic test_negative();
    logic [31:0] c0;
    do_reset();
    instr_retire = 1'b1;
    repeat (5) step();
    c0 = cyc_counter;
    store(32'h8000_0004, 32'h99, 4'b1111);
    store(32'h0000_0008, 32'h98, 4'b1111);
    store(32'h8000_0008, 32'h97, 4'b0000);
    store(32'h0000_0018, 32'h0, 4'b1111);
    store(32'h8000_0018, 32'h0, 4'b0000);
    store(32'h4000_0008, 32'h96, 4'b1111);
    checks += 4;
    if (valid !== 1'b0) begin failures++; $display("FAIL neg_valid got=%b expected=0", valid); end
    if (tx_ready_status !== 1'b1) begin failures++; $display("FAIL neg_txrdy got=%b expected=1", tx_ready_status); end
    if (cyc_counter !== c0 + 32'd6) begin failures++; $display("FAIL neg_cyc got=%0d expected=%0d", cyc_counter, c0 + 32'd6); end
    if (instr_counter !== 32'd11) begin failures++; $display("FAIL neg_instr got=%0d expected=11", instr_counter); end
    instr_retire = 1'b0;
    exp_q.push_back(8'h31);
    store(32'h8000_0008, 32'h31, 4'b0001);
    exp_q.push_back(8'h32);
    store(32'h8000_0008, 32'h32, 4'b0001);
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL neg_queued got=%b expected=1", valid); end
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks += 3;
    if (valid !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b expected=0", valid); end
    if (tx_ready_status !== 1'b1) begin failures++; $display("FAIL arst_count got=%b expected=1", tx_ready_status); end
    if (data !== 8'h00) begin failures++; $display("FAIL arst_data got=%02h expected=00", data); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic exp_ovf;
    int sz;
    logic rdy;
    logic [7:0] b;
    do_reset();
    step();
    exp_ovf = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rdy = 1'($urandom_range(0, 1));
      ready = rdy;
      sz = exp_q.size();
      if ($urandom_range(0, 9) < 8) begin
        b = 8'($urandom);
        if ((sz < DEPTH) || (rdy && sz > 0)) exp_q.push_back(b);
        else exp_ovf = 1'b1;
        store(32'h8000_0008, {24'h0, b}, 4'b0010);
      end else begin
        step();
      end
    end
    ready = 1'b1;
    repeat (8) step();
    checks += 3;
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_left got=%0d expected=0", exp_q.size()); end
    if (tx_overflow !== exp_ovf) begin failures++; $display("FAIL b2b_ovf got=%b expected=%b", tx_overflow, exp_ovf); end
    if (valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b expected=0", valid); end
    ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_full_pop();
    test_counters();
    test_negative();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
